clk_div_sched: RTL and testbench
================================

// Module: clk_div_sched
// PURPOSE
//  Runtime controller for the programmable clock divider.
//  - Accepts divide-ratio and enable updates through a valid/ready config port.
//  - Applies each update only at a period boundary, so clk_out never carries a
//    runt or stretched pulse.
//  - Produces a divided clock_out signal plus a per-period tick for downstream
//    sequencing; sits between the system configuration logic and the divider
//    consumers.
// PARAMETERS
//  CNT_W    8  width of divide ratio and period counter
//  DEF_DIV  2  divide ratio loaded at reset (must be >= 2)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous active-high reset
//  cfg_valid  in   1      config request valid
//  cfg_ready  out  1      controller can accept config this cycle
//  cfg_div    in   CNT_W  requested divide ratio N (legal 2..2^CNT_W-1)
//  cfg_en     in   1      1 = run at cfg_div, 0 = stop divider
//  clk_out    out  1      divided clock (registered)
//  tick       out  1      1-cycle pulse on last cycle of each period
//  busy       out  1      divider running or update pending
//  err        out  1      1-cycle pulse: illegal cfg_div rejected
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE, cnt=0, div=DEF_DIV.
//   - clk_out=0, tick=0, err=0, busy=0, cfg_ready=1.
//   - Reset mid-operation discards any pending config.
//  Handshake:
//   - Transfer occurs when cfg_valid && cfg_ready.
//   - cfg_ready = (state != PEND); combinational from state only, never from cfg_valid.
//  Illegal config (cfg_div < 2):
//   - Transfer still completes and err=1 the next cycle.
//   - Config is discarded entirely (no state, div or en change).
//  FSM (registered div, cnt):
//   - IDLE:
//     - Legal transfer with en=1 -> RUN: div=cfg_div, cnt=0.
//     - Legal transfer with en=0 -> div=cfg_div, stay IDLE.
//   - RUN:
//     - cnt increments each cycle and wraps N-1 -> 0.
//     - Legal transfer when cnt != N-1 -> PEND: cfg_div/cfg_en held in shadow regs.
//     - Legal transfer when cnt == N-1 -> apply directly at this boundary (as PEND apply).
//   - PEND:
//     - Counter keeps running at old N.
//     - At cnt == N-1, apply shadow:
//       - en=1 -> RUN with div=shadow, cnt=0.
//       - en=0 -> IDLE, cnt=0.
//  clk_out:
//   - Cycle after entry into RUN: clk_out=1, cnt=0.
//   - In RUN/PEND: clk_out == (cnt < (div>>1)). Odd N gives a shorter high phase (N=3: 1,0,0).
//   - In IDLE: clk_out=0.
//   - Change takes effect on the first cycle of the new period, never mid-period.
//  tick:
//   - tick=1 in cycles where state is RUN/PEND and cnt==div-1.
//   - Also asserted on the final period before stopping.
//  busy = (state != IDLE).
//  Arithmetic:
//   - cnt is CNT_W bits; compares are unsigned.
//   - div>>1 is a logical shift; no overflow possible for legal N.
// TESTING
//  1) Reset 5 cycles -> clk_out=0, tick=0, busy=0, err=0, cfg_ready=1.
//  2) cfg div=4,en=1 in IDLE -> from next cycle clk_out=1,1,0,0 repeating; tick on every 4th cycle; busy=1.
//  3) Running N=4, cfg div=6 at cnt=1 -> cfg_ready=0 until boundary.
//     Old period completes (0,0), then 1,1,1,0,0,0; cfg_ready returns to 1.
//  4) cfg div=1 or 0 -> err pulses 1 cycle; clk_out pattern and div unchanged.
//  5) Running N=3, cfg en=0 -> current period finishes with tick.
//     Then clk_out=0, busy=0, state IDLE.
//  6) rst asserted mid-PEND -> next cycle all outputs at reset values; pending config lost.

Source files
------------

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - runtime controller for a programmable clock divider with boundary-aligned updates
module clk_div_sched #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic             sh_en_q, sh_en_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             legal;
    logic             take;
    logic             last;
    logic             running_d;

    // A pending update blocks further config until it has been applied.
    assign cfg_ready = (state_q != S_PEND);
    assign busy      = (state_q != S_IDLE);
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign err       = err_q;

    // Next-state logic: updates land only on the last cycle of a period.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        sh_div_d = sh_div_q;
        sh_en_d  = sh_en_q;

        xfer  = cfg_valid && cfg_ready;
        legal = (cfg_div >= CNT_W'(2));
        take  = xfer && legal;
        err_d = xfer && !legal;
        last  = (cnt_q == div_q - CNT_W'(1));

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (take) begin
                    div_d = cfg_div;
                    if (cfg_en) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (last) begin
                    cnt_d = '0;
                    if (take) begin
                        div_d   = cfg_div;
                        state_d = cfg_en ? S_RUN : S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (take) begin
                        sh_div_d = cfg_div;
                        sh_en_d  = cfg_en;
                        state_d  = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (last) begin
                    cnt_d   = '0;
                    div_d   = sh_div_q;
                    state_d = sh_en_q ? S_RUN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from next-state values so they line up with cnt_q.
        running_d = (state_d != S_IDLE);
        clk_out_d = running_d && (cnt_d < (div_d >> 1));
        tick_d    = running_d && (cnt_d == div_d - CNT_W'(1));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEF_DIV);
            sh_div_q  <= '0;
            sh_en_q   <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sh_div_q  <= sh_div_d;
            sh_en_q   <= sh_en_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - self-checking bench for clk_div_sched
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_en = 1'b0;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    clk_div_sched #(.CNT_W(8), .DEF_DIV(2)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_en(cfg_en), .clk_out(clk_out), .tick(tick),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       valid;
        bit [7:0] div;
        bit       en;
        bit       e_clk;
        bit       e_tick;
        bit       e_busy;
        bit       e_rdy;
        bit       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit v, input bit [7:0] d, input bit e,
                       input bit c, input bit t, input bit b, input bit rd, input bit er);
        vec_t x;
        x = '{r, v, d, e, c, t, b, rd, er};
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input bit c, input bit t, input bit b,
                       input bit rd, input bit er);
        total++;
        if ({clk_out, tick, busy, cfg_ready, err} !== {c, t, b, rd, er}) begin
            bad++;
            $display("FAIL %s: clk_out/tick/busy/ready/err got %b%b%b%b%b want %b%b%b%b%b",
                     name, clk_out, tick, busy, cfg_ready, err, c, t, b, rd, er);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit [7:0] d, input bit e);
        rst = r; cfg_valid = v; cfg_div = d; cfg_en = e;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // Reference model: a running divider with a position in its period and an
    // optional pending request that is honoured at the end of a period.
    bit       m_run, m_pend, m_pen, m_err;
    int       m_div, m_pos, m_pdiv;

    task automatic model_step(input bit r, input bit v, input int d, input bit e);
        bit xfer;
        if (r) begin
            m_run = 0; m_pend = 0; m_pos = 0; m_div = 2; m_err = 0;
            return;
        end
        xfer  = v && !m_pend;
        m_err = xfer && (d < 2);
        if (!m_run) begin
            if (xfer && d >= 2) begin
                m_div = d; m_run = e; m_pos = 0;
            end
        end else begin
            if (xfer && d >= 2) begin
                m_pend = 1; m_pdiv = d; m_pen = e;
            end
            if (m_pos == m_div - 1) begin
                m_pos = 0;
                if (m_pend) begin
                    m_div = m_pdiv; m_run = m_pen; m_pend = 0;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    initial begin
        // Reset, start at N=4, then retarget to N=6 mid-period.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 4, 1, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 1, 6, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].div, vecs[i].en);
            chk($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_tick,
                vecs[i].e_busy, vecs[i].e_rdy, vecs[i].e_err);
        end

        // Illegal ratio: err pulse, period of 4 undisturbed.
        step(1, 0, 0, 0);
        step(0, 1, 4, 1);  chk("ill_start", 1, 0, 1, 1, 0);
        step(0, 1, 0, 1);  chk("ill_err0", 1, 0, 1, 1, 1);
        step(0, 1, 1, 1);  chk("ill_err1", 0, 0, 1, 1, 1);
        step(0, 0, 0, 0);  chk("ill_tick", 0, 1, 1, 1, 0);
        step(0, 0, 0, 0);  chk("ill_wrap", 1, 0, 1, 1, 0);

        // Stop at N=3: final period ends with tick, then idle.
        step(1, 0, 0, 0);
        step(0, 1, 3, 1);  chk("stop_c0", 1, 0, 1, 1, 0);
        step(0, 0, 0, 0);  chk("stop_c1", 0, 0, 1, 1, 0);
        step(0, 1, 3, 0);  chk("stop_last", 0, 1, 1, 0, 0);
        step(0, 0, 0, 0);  chk("stop_idle", 0, 0, 0, 1, 0);
        step(0, 0, 0, 0);  chk("stop_idle2", 0, 0, 0, 1, 0);

        // Reset while an update is pending discards it.
        step(0, 1, 4, 1);  chk("pr_run", 1, 0, 1, 1, 0);
        step(0, 1, 6, 1);  chk("pr_pend", 1, 0, 1, 0, 0);
        step(1, 0, 0, 0);  chk("pr_rst", 0, 0, 0, 1, 0);
        step(0, 0, 0, 0);  chk("pr_after", 0, 0, 0, 1, 0);
        step(0, 0, 0, 0);  chk("pr_after2", 0, 0, 0, 1, 0);

        // Randomized traffic against the reference model.
        step(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit       r, v, e;
            bit [7:0] d;
            bit       mc, mt;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 30);
            d = 8'($urandom_range(0, 9));
            e = ($urandom_range(0, 99) < 75);
            model_step(r, v, d, e);
            step(r, v, d, e);
            mc = m_run && (m_pos < m_div / 2);
            mt = m_run && (m_pos == m_div - 1);
            chk($sformatf("rnd%0d", i), mc, mt, m_run, !m_pend, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
